// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, instruction-memory states and
// instruction field positions.
package cpu_pkg;

  localparam int IMEM_ADDR_W = 4;
  localparam int IMEM_DATA_W = 4;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } imem_state_t;

  // Instruction word layout: [0] register select, [1] operation, [3:2] number.
  localparam int INSTR_REG_BIT = 0;
  localparam int INSTR_OP_BIT  = 1;
  localparam int INSTR_NUM_MSB = 3;
  localparam int INSTR_NUM_LSB = 2;

  localparam logic [IMEM_DATA_W-1:0] NOP_WORD = 4'h0;

endpackage

// File: rtl/imem_rd_pipe.sv
// Fixed-latency delay line for fetch responses: the granted word, its error
// flag and a valid bit travel RD_LAT register stages together.
module imem_rd_pipe #(
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_err,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
    $error("imem_rd_pipe: RD_LAT must be 1..3");
  end

  // Index 0 is the combinational grant-cycle capture, RD_LAT is the output.
  logic [RD_LAT:0]               vld_pipe;
  logic [RD_LAT:0]               err_pipe;
  logic [RD_LAT:0][DATA_W-1:0]   data_pipe;

  logic [RD_LAT-1:0]             vld_q;
  logic [RD_LAT-1:0]             err_q;
  logic [RD_LAT-1:0][DATA_W-1:0] data_q;

  assign vld_pipe  = {vld_q, in_vld};
  assign err_pipe  = {err_q, in_err};
  assign data_pipe = {data_q, in_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      err_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_pipe[RD_LAT-1:0];
      err_q  <= err_pipe[RD_LAT-1:0];
      data_q <= data_pipe[RD_LAT-1:0];
    end
  end

  assign out_vld  = vld_pipe[RD_LAT];
  assign out_err  = err_pipe[RD_LAT];
  assign out_data = data_pipe[RD_LAT];

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: owns the instruction store, the sequential
// program-load path and a fixed-latency fetch response pipeline.
module imem_responder
  import cpu_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic [ADDR_W:0]   prog_len,
  output logic              ready,
  output logic              load_ovf
);

  localparam int DEPTH = 1 << ADDR_W;
  typedef logic [ADDR_W:0] cnt_t;

  imem_state_t       state_q;
  cnt_t              wr_ptr_q, wr_ptr_d;
  cnt_t              prog_len_q;
  logic              load_ovf_q;
  logic              ready_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              ovf_hit;

  // Write-side decode; a start restarts at address 0 and may carry a word.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = wr_ptr_q[ADDR_W-1:0];
    wr_ptr_d = wr_ptr_q;
    ovf_hit  = 1'b0;
    if (load_start) begin
      wr_ptr_d = '0;
      if (load_valid) begin
        wr_en    = 1'b1;
        wr_addr  = '0;
        wr_ptr_d = cnt_t'(1);
      end
    end else if (state_q == S_LOAD && load_valid) begin
      if (wr_ptr_q == cnt_t'(DEPTH)) begin
        ovf_hit = 1'b1;
      end else begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      load_ovf_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      if (load_start) begin
        state_q    <= S_LOAD;
        ready_q    <= 1'b0;
        load_ovf_q <= 1'b0;
      end else if (state_q == S_LOAD) begin
        if (ovf_hit) load_ovf_q <= 1'b1;
        if (load_last) begin
          prog_len_q <= wr_ptr_d;
          if (wr_ptr_d != '0) begin
            state_q <= S_READY;
            ready_q <= 1'b1;
          end else begin
            state_q <= S_EMPTY;
          end
        end
      end
    end
  end

  // Store contents are deliberately not reset; prog_len guards every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= load_data;
  end

  logic              rd_err;
  logic [DATA_W-1:0] rd_word;

  // A start in READY blocks the grant so no fetch overlaps a reload.
  assign fetch_gnt = fetch_req & (state_q == S_READY) & ~load_start;
  assign rd_err    = {1'b0, fetch_addr} >= prog_len_q;
  assign rd_word   = (fetch_gnt && !rd_err) ? mem_q[fetch_addr] : DATA_W'(NOP_WORD);

  imem_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (fetch_gnt),
    .in_data  (rd_word),
    .in_err   (fetch_gnt & rd_err),
    .out_vld  (fetch_valid),
    .out_data (fetch_data),
    .out_err  (fetch_err)
  );

  assign prog_len = prog_len_q;
  assign ready    = ready_q;
  assign load_ovf = load_ovf_q;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench: three responders (RD_LAT 1,2,3) share stimulus; a
// reference model predicts grants/status and queues expected fetch responses.
module tb_imem_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_req;
  logic [3:0] fetch_addr;
  logic       load_start, load_valid, load_last;
  logic [3:0] load_data;

  logic       gnt [3];
  logic       vld [3];
  logic       err [3];
  logic [3:0] data [3];
  logic [4:0] plen [3];
  logic       rdy [3];
  logic       ovf [3];

  always #5 clk = ~clk;

  imem_responder #(.ADDR_W(4), .DATA_W(4), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(gnt[0]), .fetch_valid(vld[0]), .fetch_data(data[0]), .fetch_err(err[0]),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .prog_len(plen[0]), .ready(rdy[0]), .load_ovf(ovf[0]));

  imem_responder #(.ADDR_W(4), .DATA_W(4), .RD_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(gnt[1]), .fetch_valid(vld[1]), .fetch_data(data[1]), .fetch_err(err[1]),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .prog_len(plen[1]), .ready(rdy[1]), .load_ovf(ovf[1]));

  imem_responder #(.ADDR_W(4), .DATA_W(4), .RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(gnt[2]), .fetch_valid(vld[2]), .fetch_data(data[2]), .fetch_err(err[2]),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .prog_len(plen[2]), .ready(rdy[2]), .load_ovf(ovf[2]));

  typedef struct {
    int         due;
    logic [3:0] data;
    logic       err;
  } exp_t;

  exp_t sb [3][$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: loading/ready flags, fill count, program length, store.
  bit         m_load, m_ready, m_ovf;
  int         m_wptr, m_plen;
  logic [3:0] m_mem [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every fetch_valid must match the oldest queued entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (vld[d]) begin
          if (sb[d].size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid lat%0d: got valid expected none (cycle %0d)", d + 1, cyc);
          end else begin
            e = sb[d].pop_front();
            chk($sformatf("valid_cycle lat%0d", d + 1), cyc, e.due);
            chk($sformatf("fetch_data lat%0d", d + 1), data[d], e.data);
            chk($sformatf("fetch_err lat%0d", d + 1), err[d], e.err);
          end
        end else if (sb[d].size() > 0 && sb[d][0].due <= cyc) begin
          checks++; errors++;
          $display("FAIL missing_valid lat%0d: got none expected valid at cycle %0d (cycle %0d)",
                   d + 1, sb[d][0].due, cyc);
          void'(sb[d].pop_front());
        end
      end
    end
  end

  task automatic clr_inputs();
    fetch_req = 0; fetch_addr = 0;
    load_start = 0; load_valid = 0; load_data = 0; load_last = 0;
  endtask

  // One clock: check status against the model, predict responses, advance model.
  task automatic tick();
    bit g;
    @(negedge clk);
    g = fetch_req && m_ready && !load_start;
    for (int d = 0; d < 3; d++) begin
      chk("fetch_gnt", gnt[d], g);
      chk("ready", rdy[d], m_ready);
      chk("prog_len", plen[d], m_plen);
      chk("load_ovf", ovf[d], m_ovf);
    end
    if (g)
      for (int d = 0; d < 3; d++)
        sb[d].push_back('{due: cyc + d + 1,
                          data: (int'(fetch_addr) < m_plen) ? m_mem[fetch_addr] : 4'h0,
                          err: int'(fetch_addr) >= m_plen});
    if (load_start) begin
      m_load = 1; m_ready = 0; m_ovf = 0; m_wptr = 0;
      if (load_valid) begin m_mem[0] = load_data; m_wptr = 1; end
    end else if (m_load) begin
      if (load_valid) begin
        if (m_wptr < 16) begin m_mem[m_wptr] = load_data; m_wptr++; end
        else m_ovf = 1;
      end
      if (load_last) begin m_plen = m_wptr; m_load = 0; m_ready = (m_wptr > 0); end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    clr_inputs();
    repeat (n) tick();
  endtask

  task automatic fetch(input int a);
    clr_inputs();
    fetch_req = 1; fetch_addr = 4'(a);
    tick();
  endtask

  logic [3:0] prog_q [$];

  task automatic load_prog();
    clr_inputs(); load_start = 1; tick();
    for (int i = 0; i < prog_q.size(); i++) begin
      clr_inputs();
      load_valid = 1; load_data = prog_q[i]; load_last = (i == prog_q.size() - 1);
      tick();
    end
    if (prog_q.size() == 0) begin clr_inputs(); load_last = 1; tick(); end
    clr_inputs();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic async_reset();
    #1 rst = 1;
    for (int d = 0; d < 3; d++) sb[d].delete();
    m_load = 0; m_ready = 0; m_ovf = 0; m_wptr = 0; m_plen = 0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_valid", vld[d], 1'b0);
      chk("rst_ready", rdy[d], 1'b0);
      chk("rst_prog_len", plen[d], 0);
      chk("rst_load_ovf", ovf[d], 1'b0);
    end
    clr_inputs();
    @(posedge clk); @(posedge clk); #1 rst = 0;
  endtask

  initial begin
    int r;
    for (int i = 0; i < 16; i++) m_mem[i] = 4'h0;
    m_load = 0; m_ready = 0; m_ovf = 0; m_wptr = 0; m_plen = 0;
    clr_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_valid", vld[d], 1'b0);
      chk("reset_prog_len", plen[d], 0);
      chk("reset_ready", rdy[d], 1'b0);
    end
    rst = 0;

    // Empty store: requests are never granted.
    fetch_req = 1; fetch_addr = 0;
    repeat (10) tick();

    // Three-word program, back-to-back fetches, then an out-of-range fetch.
    prog_q = '{4'h5, 4'hA, 4'h3};
    load_prog();
    fetch(0); fetch(1); fetch(2);
    idle(4);
    fetch(7);
    idle(4);

    // Seventeen words: last one dropped, overflow flagged, length 16.
    prog_q.delete();
    for (int i = 0; i < 16; i++) prog_q.push_back(4'(i));
    prog_q.push_back(4'h9);
    load_prog();
    fetch(15); fetch(0); fetch(8);
    idle(4);

    // Grant at addr 1, reload starts the next cycle; old word still returns.
    fetch(1);
    clr_inputs(); load_start = 1; tick();
    clr_inputs(); fetch_req = 1; fetch_addr = 1;
    repeat (3) tick();
    load_valid = 1; load_data = 4'hC; tick();
    load_valid = 0; load_last = 1; tick();
    fetch(0); fetch(1);
    idle(4);

    // Empty load ends back in the empty state; start+valid writes address 0.
    prog_q.delete();
    load_prog();
    fetch(0);
    clr_inputs(); load_start = 1; load_valid = 1; load_data = 4'h7; tick();
    clr_inputs(); load_last = 1; tick();
    fetch(0); fetch(1);
    idle(4);

    // Reset with fetches in flight.
    fetch(0); fetch(0);
    async_reset();
    idle(4);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      clr_inputs();
      r = $urandom_range(0, 99);
      if (r < 5) begin
        load_start = 1; load_valid = $urandom_range(0, 1); load_data = 4'($urandom);
      end else if (m_load) begin
        load_valid = ($urandom_range(0, 2) != 0); load_data = 4'($urandom);
        load_last = ($urandom_range(0, 23) == 0);
        fetch_req = $urandom_range(0, 1); fetch_addr = 4'($urandom);
      end else begin
        fetch_req = ($urandom_range(0, 3) != 0); fetch_addr = 4'($urandom);
        load_valid = ($urandom_range(0, 9) == 0); load_last = ($urandom_range(0, 9) == 0);
        load_data = 4'($urandom);
      end
      tick();
    end
    idle(5);

    // Reset during a load after two writes.
    prog_q = '{4'h1, 4'h2};
    clr_inputs(); load_start = 1; tick();
    load_start = 0; load_valid = 1; load_data = 4'h1; tick();
    load_data = 4'h2; tick();
    async_reset();
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Responder end of the instruction-fetch interface: control_unit issues fetch requests by PC and this block returns 4-bit instruction words with a fixed, parameterised latency.
- Also owns the program-load path. A sequential writer interface fills the instruction store from address 0 and records the program length.
- Replaces the bare combinational instr_mem lookup. Sits between control_unit and the program loader / testbench.

Parameters:
- ADDR_W, 4, fetch address width; store depth is 2**ADDR_W (16 words).
- DATA_W, 4, instruction width: [0] register select, [1] operation, [3:2] number.
- RD_LAT, 1, cycles from grant to fetch_valid; legal values 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_req  in  1  control_unit requests the word at fetch_addr.
- fetch_addr  in  ADDR_W  program counter.
- fetch_gnt  out  1  request accepted this cycle.
- fetch_valid  out  1  fetch_data/fetch_err valid, one-cycle pulse per grant.
- fetch_data  out  DATA_W  instruction word (4'h0 when fetch_err).
- fetch_err  out  1  fetched address >= prog_len.
- load_start  in  1  begin/restart a program load.
- load_valid  in  1  load_data is written at the write pointer.
- load_data  in  DATA_W  instruction to store.
- load_last  in  1  final word of the load; may accompany load_valid or arrive alone.
- prog_len  out  ADDR_W+1  number of words in the current program (0..16).
- ready  out  1  state == S_READY.
- load_ovf  out  1  sticky flag: a word was dropped because the store was full.

Behaviour:
- Reset (async, active-high): state=S_EMPTY, wr_ptr=0, prog_len=0, load_ovf=0, all fetch outputs 0, latency pipeline cleared. Store contents are not reset; they are guarded by prog_len.
- States:
  - S_EMPTY -> S_LOAD on load_start.
  - S_LOAD -> S_READY on load_last with final prog_len>0.
  - S_LOAD -> S_EMPTY on load_last with final prog_len==0.
  - S_READY -> S_LOAD on load_start.
  - Any state: load_start clears wr_ptr and load_ovf.
  - load_start in S_LOAD restarts the load at address 0.
- Load:
  - In S_LOAD, load_valid writes store[wr_ptr]=load_data and increments wr_ptr.
  - If wr_ptr==16, the write is dropped, load_ovf is set, and wr_ptr holds.
  - On load_last, prog_len=wr_ptr, counting a same-cycle valid write.
  - load_valid/load_last outside S_LOAD are ignored.
  - load_start and load_valid in the same cycle: the start takes effect, and the data is written at address 0 with wr_ptr->1.
- Fetch:
  - fetch_gnt = fetch_req & (state==S_READY), combinational.
  - On grant, the store word and the compare fetch_addr>=prog_len are captured in the same cycle, then delayed RD_LAT-1 further register stages.
  - fetch_valid rises exactly RD_LAT cycles after the grant cycle.
  - Back-to-back grants are allowed every cycle; throughput is 1 word/cycle.
  - No backpressure: control_unit must accept fetch_valid when it appears.
  - fetch_err=1 forces fetch_data=4'h0 (NOP).
- Simultaneous events:
  - Grants issued before load_start complete normally with their pre-load data; the pipeline drains and is not flushed.
  - No grant is issued from the cycle load_start is sampled.
  - Reset mid-load or mid-fetch: everything returns to reset values immediately; in-flight fetch_valid pulses are lost.
- Address arithmetic: ADDR_W-bit, no wrap handling needed. prog_len is ADDR_W+1 bits so that 16 is representable.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W/DATA_W defaults.
  - imem_state_t enum {S_EMPTY, S_LOAD, S_READY}.
  - Instruction field constants INSTR_REG_BIT=0, INSTR_OP_BIT=1, INSTR_NUM_MSB=3, INSTR_NUM_LSB=2.
  - NOP word 4'h0.
- One sub-module: imem_rd_pipe, the RD_LAT-deep valid/data/err delay line. The FSM, write pointer and store stay in imem_responder.

Test Plan:
- Reset then fetch_req=1, addr=0 -> fetch_gnt=0, ready=0, prog_len=0, no fetch_valid for 10 cycles.
- load_start; load words 4'h5, 4'hA, 4'h3 with load_last on the third -> prog_len=3, ready=1. Fetch addr 0,1,2 back-to-back (RD_LAT=1) -> fetch_valid on 3 consecutive cycles, data 5, A, 3, fetch_err=0.
- Same program, fetch addr=7 -> fetch_valid after RD_LAT cycles, fetch_data=0, fetch_err=1. Repeat with RD_LAT=3 -> valid exactly 3 cycles after grant.
- Load 17 words (0..F, then 4'h9) with load_last on the 17th -> load_ovf=1, prog_len=16, store[0]=0 unchanged, fetch addr 15 returns 4'hF.
- Fetch granted at addr 1, load_start asserted the next cycle, RD_LAT=2 -> old word still returned with fetch_valid. fetch_gnt=0 thereafter until the new load completes.
- Assert rst during S_LOAD after 2 writes -> state S_EMPTY, prog_len=0, ready=0, load_ovf=0, fetch_valid=0 in the same cycle (async).
